// File: rtl/iob_cpu_bus_arbiter_pkg.sv
// Shared types and helpers for the two-master iob bus arbiter.
// Holds the FSM state encoding, priority-mode constants and the grant selection rule.
package iob_cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  localparam int unsigned PrioRr    = 0;
  localparam int unsigned PrioFixed = 1;

  // Only meaningful when at least one slot is pending.
  function automatic logic pick_grant(input logic        pend0,
                                      input logic        pend1,
                                      input logic        last_grant,
                                      input int unsigned prio_mode);
    logic g;
    if (pend0 && pend1) begin
      g = (prio_mode == PrioFixed) ? 1'b1 : ~last_grant;
    end else begin
      g = pend1;
    end
    return g;
  endfunction

endpackage

// File: rtl/iob_cpu_bus_arbiter_slot.sv
// One latched request slot: captures a single-cycle request pulse and holds it until served.
// A new pulse is accepted while empty or in the same cycle the held request completes.
module iob_req_slot #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                clear_i,
  output logic                pend_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o
);

  logic                pend_q,  pend_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                capture;

  // Pulses arriving while the slot is busy and not completing are dropped.
  assign capture = valid_i & (~pend_q | clear_i);

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (capture) begin
      pend_d  = 1'b1;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      wstrb_d = wstrb_i;
    end else if (clear_i) begin
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wstrb_o = wstrb_q;

endmodule

// File: rtl/iob_cpu_bus_arbiter.sv
// Shares one iob native slave port between the CPU instruction (m0) and data (m1) buses.
// Requests are latched per master, arbitrated, issued one at a time, and responses routed back.
module iob_cpu_bus_arbiter
  import iob_cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready
);

  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_e         state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               s_valid_q, s_valid_d;
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [DATA_W-1:0]  s_wdata_q, s_wdata_d;
  logic [StrbW-1:0]   s_wstrb_q, s_wstrb_d;

  logic               pend0, pend1;
  logic [ADDR_W-1:0]  slot0_addr, slot1_addr;
  logic [DATA_W-1:0]  slot0_wdata, slot1_wdata;
  logic [StrbW-1:0]   slot0_wstrb, slot1_wstrb;
  logic               complete;

  // s_ready only means something while a transaction is outstanding.
  assign complete = s_ready & (state_q != StIdle);

  iob_req_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (m0_valid),
    .addr_i  (m0_addr),
    .wdata_i (m0_wdata),
    .wstrb_i (m0_wstrb),
    .clear_i (complete & ~grant_q),
    .pend_o  (pend0),
    .addr_o  (slot0_addr),
    .wdata_o (slot0_wdata),
    .wstrb_o (slot0_wstrb)
  );

  iob_req_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (m1_valid),
    .addr_i  (m1_addr),
    .wdata_i (m1_wdata),
    .wstrb_i (m1_wstrb),
    .clear_i (complete & grant_q),
    .pend_o  (pend1),
    .addr_o  (slot1_addr),
    .wdata_o (slot1_wdata),
    .wstrb_o (slot1_wstrb)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_valid_d    = 1'b0;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (pend0 | pend1) begin
          grant_d   = pick_grant(pend0, pend1, last_grant_q, PRIO_MODE);
          s_addr_d  = grant_d ? slot1_addr  : slot0_addr;
          s_wdata_d = grant_d ? slot1_wdata : slot0_wdata;
          s_wstrb_d = grant_d ? slot1_wstrb : slot0_wstrb;
          s_valid_d = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (s_ready) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else begin
          state_d      = StWait;
        end
      end
      StWait: begin
        if (s_ready) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_valid_q    <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_valid_q    <= s_valid_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;

  assign m0_ready = complete & ~grant_q;
  assign m1_ready = complete & grant_q;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// Directed bench for iob_cpu_bus_arbiter: a cycle table for single/dual requests, plus
// hand sequences for fairness, fixed priority and reset in the middle of a transaction.
module tb_iob_cpu_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_valid [2];
  logic [31:0] m0_addr  [2];
  logic [31:0] m0_wdata [2];
  logic [3:0]  m0_wstrb [2];
  logic [31:0] m0_rdata [2];
  logic        m0_ready [2];
  logic        m1_valid [2];
  logic [31:0] m1_addr  [2];
  logic [31:0] m1_wdata [2];
  logic [3:0]  m1_wstrb [2];
  logic [31:0] m1_rdata [2];
  logic        m1_ready [2];
  logic        s_valid  [2];
  logic [31:0] s_addr   [2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic [31:0] s_rdata  [2];
  logic        s_ready  [2];

  int total = 0;
  int bad   = 0;

  // Instance 0: round-robin, instance 1: fixed priority.
  iob_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_wstrb(m0_wstrb[0]), .m0_rdata(m0_rdata[0]), .m0_ready(m0_ready[0]),
    .m1_valid(m1_valid[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_wstrb(m1_wstrb[0]), .m1_rdata(m1_rdata[0]), .m1_ready(m1_ready[0]),
    .s_valid(s_valid[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
    .s_wstrb(s_wstrb[0]), .s_rdata(s_rdata[0]), .s_ready(s_ready[0])
  );

  iob_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dut_fx (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_wstrb(m0_wstrb[1]), .m0_rdata(m0_rdata[1]), .m0_ready(m0_ready[1]),
    .m1_valid(m1_valid[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_wstrb(m1_wstrb[1]), .m1_rdata(m1_rdata[1]), .m1_ready(m1_ready[1]),
    .s_valid(s_valid[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
    .s_wstrb(s_wstrb[1]), .s_rdata(s_rdata[1]), .s_ready(s_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          v0;
    logic [31:0] a0;
    bit          v1;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [3:0]  ws1;
    bit          rdy;
    logic [31:0] rd;
    bit          e_sv;
    logic [31:0] e_sa;
    logic [31:0] e_swd;
    logic [3:0]  e_sws;
    bit          e_r0;
    bit          e_r1;
  } vec_t;

  localparam int NVec = 18;
  vec_t vecs [NVec];

  function automatic vec_t mk(bit r, bit v0, logic [31:0] a0, bit v1, logic [31:0] a1,
                              logic [31:0] wd1, logic [3:0] ws1, bit rdy, logic [31:0] rd,
                              bit esv, logic [31:0] esa, logic [31:0] eswd, logic [3:0] esws,
                              bit er0, bit er1);
    vec_t v;
    v.rst = r;  v.v0 = v0;   v.a0 = a0;   v.v1 = v1;   v.a1 = a1;
    v.wd1 = wd1; v.ws1 = ws1; v.rdy = rdy; v.rd = rd;
    v.e_sv = esv; v.e_sa = esa; v.e_swd = eswd; v.e_sws = esws;
    v.e_r0 = er0; v.e_r1 = er1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    m0_valid[d] = 1'b0; m0_addr[d] = '0; m0_wdata[d] = '0; m0_wstrb[d] = '0;
    m1_valid[d] = 1'b0; m1_addr[d] = '0; m1_wdata[d] = '0; m1_wstrb[d] = '0;
    s_ready[d]  = 1'b0; s_rdata[d] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both masters re-issue the cycle after their own ready; slave answers one cycle after s_valid.
  task automatic fairness(input int d, input bit [7:0] exp_g);
    bit [7:0] g = '0;
    int  n = 0;
    int  cyc = 0;
    bit  re0 = 1'b1;
    bit  re1 = 1'b1;
    bit  resp = 1'b0;
    while (cyc < 200 && !(n == 8 && !resp)) begin
      @(negedge clk);
      m0_valid[d] = re0; m0_addr[d] = 32'h1000;
      m1_valid[d] = re1; m1_addr[d] = 32'h2000;
      s_ready[d]  = resp; s_rdata[d] = 32'hC0DE_0000 + 32'(n);
      re0 = 1'b0; re1 = 1'b0; resp = 1'b0;
      #1;
      if (m0_ready[d] && n < 8) re0 = 1'b1;
      if (m1_ready[d] && n < 8) re1 = 1'b1;
      if (s_valid[d] && n < 8) begin
        g[n] = (s_addr[d] == 32'h2000);
        n++;
        resp = 1'b1;
      end
      cyc++;
    end
    chk($sformatf("fair%0d_count", d), 0, 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fair%0d_grant", d), i, 32'(g[i]), 32'(exp_g[i]));
    end
    idle_inputs(d);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);

    // Row: rst v0 a0 v1 a1 wd1 ws1 rdy rd | sv sa swd sws r0 r1
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 32'h100, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h100, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 32'h10, 1, 32'h20, 32'h1234_5678, 4'hF, 0, 0,
                  0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5, 1, 32'h10, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h20, 32'h1234_5678, 4'hF, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      m0_valid[0] = vecs[i].v0;  m0_addr[0] = vecs[i].a0;
      m1_valid[0] = vecs[i].v1;  m1_addr[0] = vecs[i].a1;
      m1_wdata[0] = vecs[i].wd1; m1_wstrb[0] = vecs[i].ws1;
      s_ready[0]  = vecs[i].rdy; s_rdata[0] = vecs[i].rd;
      #1;
      chk("s_valid", i, 32'(s_valid[0]), 32'(vecs[i].e_sv));
      chk("m0_ready", i, 32'(m0_ready[0]), 32'(vecs[i].e_r0));
      chk("m1_ready", i, 32'(m1_ready[0]), 32'(vecs[i].e_r1));
      if (vecs[i].e_sv || vecs[i].rst) begin
        chk("s_addr", i, s_addr[0], vecs[i].e_sa);
        chk("s_wdata", i, s_wdata[0], vecs[i].e_swd);
        chk("s_wstrb", i, 32'(s_wstrb[0]), 32'(vecs[i].e_sws));
      end
      if (vecs[i].e_r0) chk("m0_rdata", i, m0_rdata[0], vecs[i].rd);
      if (vecs[i].e_r1) chk("m1_rdata", i, m1_rdata[0], vecs[i].rd);
    end

    // Fairness: round-robin alternates starting with m0; fixed priority starts with m1.
    do_reset();
    fairness(0, 8'b1010_1010);
    do_reset();
    fairness(1, 8'b0101_0101);

    // Reset while waiting on the slave with both slots pending.
    do_reset();
    @(negedge clk);
    m0_valid[0] = 1'b1; m0_addr[0] = 32'h300;
    m1_valid[0] = 1'b1; m1_addr[0] = 32'h400;
    @(negedge clk);
    idle_inputs(0);
    @(negedge clk);
    #1 chk("rw_req_valid", 0, 32'(s_valid[0]), 32'd1);
    @(negedge clk);
    #1 chk("rw_wait_valid", 0, 32'(s_valid[0]), 32'd0);
    #1 rst = 1'b1; s_ready[0] = 1'b1;
    #1;
    chk("rw_rst_m0_ready", 0, 32'(m0_ready[0]), 32'd0);
    chk("rw_rst_m1_ready", 0, 32'(m1_ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_late_m0_ready", 0, 32'(m0_ready[0]), 32'd0);
    chk("rw_late_m1_ready", 0, 32'(m1_ready[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_ready[0] = 1'b0;
      #1 chk("rw_quiet_valid", i, 32'(s_valid[0]), 32'd0);
    end
    @(negedge clk);
    m1_valid[0] = 1'b1; m1_addr[0] = 32'h500;
    @(negedge clk);
    idle_inputs(0);
    @(negedge clk);
    #1;
    chk("rw_new_valid", 0, 32'(s_valid[0]), 32'd1);
    chk("rw_new_addr", 0, s_addr[0], 32'h500);
    @(negedge clk);
    s_ready[0] = 1'b1; s_rdata[0] = 32'h0000_0500;
    #1 chk("rw_new_m1_ready", 0, 32'(m1_ready[0]), 32'd1);

    // Reset during the request cycle drops s_valid immediately.
    @(negedge clk);
    idle_inputs(0);
    m0_valid[0] = 1'b1; m0_addr[0] = 32'h600;
    @(negedge clk);
    idle_inputs(0);
    @(negedge clk);
    #1 chk("rr_req_valid", 0, 32'(s_valid[0]), 32'd1);
    #1 rst = 1'b1;
    #1 chk("rr_rst_valid", 0, 32'(s_valid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("rr_after_valid", 0, 32'(s_valid[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
